// File: rtl/activation_pipe.sv
// activation_pipe: two-stage valid/ready pipeline applying one of six activations to LANES fixed-point lanes
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_mode/in_data upstream beat;
// out_valid/out_ready/out_data/out_sat downstream beat; busy = any stage occupied.
module activation_pipe #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 8,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_mode,
  input  logic [WIDTH*LANES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic                   busy
);
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic signed [WIDTH-1:0] ZERO    = '0;
  localparam logic signed [WIDTH:0]   ONE_X   = (WIDTH+1)'(1 << FRAC);
  localparam logic signed [WIDTH:0]   HALF_X  = (WIDTH+1)'((1 << FRAC) >> 1);
  // returns {clamped, result}; hard-sigmoid uses one extra bit so the add cannot wrap
  function automatic logic [WIDTH:0] act(input logic [2:0] m, input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH:0] t;
    t = ($signed({x[WIDTH-1], x}) >>> 2) + HALF_X;
    case (m)
      3'd0: return {1'b0, x};
      3'd1: return {1'b0, x[WIDTH-1] ? ZERO : ONE};
      3'd2: return {1'b0, x[WIDTH-1] ? ZERO : x};
      3'd3: return x > ONE ? {1'b1, ONE} : x < NEG_ONE ? {1'b1, NEG_ONE} : {1'b0, x};
      3'd4: return {1'b0, x[WIDTH-1] ? x >>> LEAK_SHIFT : x};
      3'd5: return t[WIDTH] ? {1'b1, ZERO} : t > ONE_X ? {1'b1, ONE} : {1'b0, t[WIDTH-1:0]};
      default: return '0;
    endcase
  endfunction
  logic                   s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, s2_adv;
  logic [2:0]             s1_mode_d, s1_mode_q;
  logic [WIDTH*LANES-1:0] s1_data_d, s1_data_q, s2_data_d, s2_data_q, res;
  logic [LANES-1:0]       s2_sat_d, s2_sat_q, sat;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign {sat[k], res[k*WIDTH +: WIDTH]} = act(s1_mode_q, s1_data_q[k*WIDTH +: WIDTH]);
  end
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_adv;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_mode_d  = in_ready && in_valid ? in_mode : s1_mode_q;
    s1_data_d  = in_ready && in_valid ? in_data : s1_data_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_data_d  = s2_adv && s1_valid_q ? res : s2_data_q;
    s2_sat_d   = s2_adv && s1_valid_q ? sat : s2_sat_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign busy      = s1_valid_q || s2_valid_q;
endmodule
